pos_frame_latch: RTL and testbench

POS_FRAME_LATCH -- requirements
Module: pos_frame_latch

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/sync_fall_detect.sv | 26 ++
 rtl/pos_frame_latch.sv | 121 ++++++++++++
 tb/tb_pos_frame_latch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA sprite position path: screen limits, CPU register
// map, latch FSM states and the packed position bit-fields.
package vga_pkg;

  localparam int unsigned H_MAX_DEF = 639;
  localparam int unsigned V_MAX_DEF = 479;

  localparam int unsigned COORD_W = 10;

  // CPU write address map
  localparam logic [1:0] ADDR_MARIO  = 2'd0;
  localparam logic [1:0] ADDR_BARRIL = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_COMMIT = 2'd3;

  // Packed position layout: h in [25:16], v in [9:0], every other bit zero
  localparam int unsigned POS_H_LSB = 16;
  localparam int unsigned POS_H_MSB = 25;
  localparam int unsigned POS_V_LSB = 0;
  localparam int unsigned POS_V_MSB = 9;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCommit
  } state_t;

  // Saturate a coordinate at the screen edge instead of wrapping.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] coord,
                                                     input logic [COORD_W-1:0] limit);
    return (coord > limit) ? limit : coord;
  endfunction

  function automatic logic [31:0] pack_pos(input logic [COORD_W-1:0] h,
                                           input logic [COORD_W-1:0] v);
    logic [31:0] pos;
    pos                      = '0;
    pos[POS_H_MSB:POS_H_LSB] = h;
    pos[POS_V_MSB:POS_V_LSB] = v;
    return pos;
  endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchronizer for an asynchronous active-low strobe, followed by a
// third stage that flags the high-to-low transition for one clk cycle.
module sync_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Sync chain and edge-detect stage; all idle high so reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/pos_frame_latch.sv
// CPU-written sprite positions held in shadow registers and transferred to the
// display side only on a vsync falling edge after an explicit commit request,
// so the renderer never sees a half-updated frame.
module pos_frame_latch
  import vga_pkg::*;
#(
  parameter int unsigned H_MAX       = H_MAX_DEF,
  parameter int unsigned V_MAX       = V_MAX_DEF,
  parameter logic [31:0] MARIO_INIT  = {6'b0, 10'd155, 6'b0, 10'd427},
  parameter logic [31:0] BARRIL_INIT = {6'b0, 10'd215, 6'b0, 10'd236}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        vsync,
  output logic [31:0] mario_pos,
  output logic [31:0] barril_pos,
  output logic        in1,
  output logic [15:0] frame_cnt
);

  localparam logic [COORD_W-1:0] HLim = COORD_W'(H_MAX);
  localparam logic [COORD_W-1:0] VLim = COORD_W'(V_MAX);

  logic        wr_fire;
  logic        commit_req;
  logic        vsync_fall;
  logic [31:0] wr_pos;
  logic        unused_data;

  logic [31:0] mario_sh_q;
  logic [31:0] barril_sh_q;
  logic        in1_sh_q;

  state_t      state_q;
  logic        wr_ready_q;
  logic [31:0] mario_pos_q;
  logic [31:0] barril_pos_q;
  logic        in1_q;
  logic [15:0] frame_cnt_q;

  assign wr_fire    = wr_valid & wr_ready_q;
  assign commit_req = wr_fire && (wr_addr == ADDR_COMMIT);

  assign wr_pos = pack_pos(clamp_coord(wr_data[POS_H_MSB:POS_H_LSB], HLim),
                           clamp_coord(wr_data[POS_V_MSB:POS_V_LSB], VLim));

  // Padding bits of the position word are dropped on purpose.
  assign unused_data = ^{wr_data[31:26], wr_data[15:10]};

  sync_fall_detect u_vsync_fall (
    .clk      (clk),
    .reset    (reset),
    .async_in (vsync),
    .fall     (vsync_fall)
  );

  // Shadow registers: take every accepted write, including while ARMED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mario_sh_q  <= MARIO_INIT;
      barril_sh_q <= BARRIL_INIT;
      in1_sh_q    <= 1'b0;
    end else if (wr_fire) begin
      case (wr_addr)
        ADDR_MARIO:  mario_sh_q  <= wr_pos;
        ADDR_BARRIL: barril_sh_q <= wr_pos;
        ADDR_CTRL:   in1_sh_q    <= wr_data[0];
        default:     ;
      endcase
    end
  end

  // Commit FSM; outputs are loaded on the edge that enters COMMIT so they land
  // three clk edges after vsync is first sampled low, and COMMIT then stalls writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wr_ready_q   <= 1'b1;
      mario_pos_q  <= MARIO_INIT;
      barril_pos_q <= BARRIL_INIT;
      in1_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // An edge coinciding with the request is not used; wait for the next.
          if (commit_req) state_q <= StArmed;
        end
        StArmed: begin
          if (vsync_fall) begin
            state_q      <= StCommit;
            wr_ready_q   <= 1'b0;
            mario_pos_q  <= mario_sh_q;
            barril_pos_q <= barril_sh_q;
            in1_q        <= in1_sh_q;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
          end
        end
        StCommit: begin
          state_q    <= StIdle;
          wr_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= StIdle;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready   = wr_ready_q;
  assign mario_pos  = mario_pos_q;
  assign barril_pos = barril_pos_q;
  assign in1        = in1_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pos_frame_latch.sv
// Bench for pos_frame_latch: random CPU writes against a frame-level model of
// shadow / committed state, plus directed reset, clamp, wrap and stall cases.
module tb_pos_frame_latch;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        vsync;
  logic [31:0] mario_pos;
  logic [31:0] barril_pos;
  logic        in1;
  logic [15:0] frame_cnt;

  int vectors;
  int miscompares;

  // Reference model: what the CPU has written, and what the display shows
  logic [31:0] sh_m, sh_b, out_m, out_b;
  logic        sh_i, out_i;
  int          fcnt_m;
  bit          armed;

  localparam logic [31:0] MarioRst  = 32'h009B01AB;
  localparam logic [31:0] BarrilRst = 32'h00D700EC;

  pos_frame_latch dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .vsync      (vsync),
    .mario_pos  (mario_pos),
    .barril_pos (barril_pos),
    .in1        (in1),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Expected packed position: saturate h at 639 and v at 479, drop other bits
  function automatic logic [31:0] exp_pos(input logic [31:0] d);
    int h, v;
    h = int'((d >> 16) % 1024);
    v = int'(d % 1024);
    if (h > 639) h = 639;
    if (v > 479) v = 479;
    return 32'(h * 65536 + v);
  endfunction

  task automatic model_reset();
    sh_m = MarioRst;  out_m = MarioRst;
    sh_b = BarrilRst; out_b = BarrilRst;
    sh_i = 1'b0;      out_i = 1'b0;
    fcnt_m = 0;
    armed  = 1'b0;
  endtask

  // One accepted write (never issued during COMMIT)
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
    case (a)
      2'd0:    sh_m = exp_pos(d);
      2'd1:    sh_b = exp_pos(d);
      2'd2:    sh_i = d[0];
      default: armed = 1'b1;
    endcase
  endtask

  // Drop vsync, check nothing moves for two edges, then check the third edge
  task automatic frame_pulse(input string tag);
    bit exp_ready;
    @(negedge clk);
    vsync = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      vectors++;
      if (mario_pos !== out_m || frame_cnt !== 16'(fcnt_m)) begin
        miscompares++;
        $display("FAIL %s_early_e%0d: got mario=%h cnt=%h expected mario=%h cnt=%h",
                 tag, e, mario_pos, frame_cnt, out_m, 16'(fcnt_m));
      end
    end
    @(negedge clk);
    exp_ready = 1'b1;
    if (armed) begin
      out_m = sh_m; out_b = sh_b; out_i = sh_i;
      fcnt_m = (fcnt_m + 1) % 65536;
      armed = 1'b0;
      exp_ready = 1'b0;
    end
    vectors++;
    if (mario_pos !== out_m || barril_pos !== out_b || in1 !== out_i ||
        frame_cnt !== 16'(fcnt_m) || wr_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL %s_edge3: got m=%h b=%h in1=%b cnt=%h rdy=%b expected m=%h b=%h in1=%b cnt=%h rdy=%b",
               tag, mario_pos, barril_pos, in1, frame_cnt, wr_ready,
               out_m, out_b, out_i, 16'(fcnt_m), exp_ready);
    end
    @(negedge clk);
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_back: got wr_ready=%b expected 1", tag, wr_ready);
    end
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; vsync = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (mario_pos !== 32'h009B01AB || barril_pos !== 32'h00D700EC || in1 !== 1'b0 ||
        frame_cnt !== 16'h0000 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: got m=%h b=%h in1=%b cnt=%h rdy=%b expected 009b01ab 00d700ec 0 0000 1",
               mario_pos, barril_pos, in1, frame_cnt, wr_ready);
    end
  endtask

  task automatic test_no_commit();
    wr(2'd0, $urandom());
    wr(2'd1, $urandom());
    wr(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) frame_pulse("no_commit");
    vectors++;
    if (mario_pos !== MarioRst || barril_pos !== BarrilRst || in1 !== 1'b0 ||
        frame_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL no_commit_final: got m=%h b=%h in1=%b cnt=%h expected init, cnt 0000",
               mario_pos, barril_pos, in1, frame_cnt);
    end
  endtask

  task automatic test_commit();
    wr(2'd0, {6'd0, 10'd100, 6'd0, 10'd200});
    wr(2'd3, $urandom());
    frame_pulse("commit");
    vectors++;
    if (mario_pos !== 32'h006400C8 || frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL commit_mario: got m=%h cnt=%h expected 006400c8 0001", mario_pos, frame_cnt);
    end
  endtask

  task automatic test_clamp();
    wr(2'd1, {6'd0, 10'd1000, 6'd0, 10'd600});
    wr(2'd3, 32'h0);
    frame_pulse("clamp");
    vectors++;
    if (barril_pos !== 32'h027F01DF) begin
      miscompares++;
      $display("FAIL clamp_barril: got %h expected 027f01df", barril_pos);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) wr(2'($urandom_range(0, 2)), $urandom());
      wr(2'd3, $urandom());
      // Writes and repeat commits while ARMED
      nw = int'($urandom_range(0, 3));
      for (int k = 0; k < nw; k++) wr(2'($urandom_range(0, 3)), $urandom());
      frame_pulse("random");
    end
  endtask

  task automatic test_same_cycle();
    wr(2'd0, $urandom());
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Detected edge is live during this cycle; commit accepted on the same edge
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = '0;
    @(negedge clk);
    wr_valid = 1'b0;
    armed = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (mario_pos !== out_m || frame_cnt !== 16'(fcnt_m)) begin
      miscompares++;
      $display("FAIL same_cycle_hold: got m=%h cnt=%h expected m=%h cnt=%h",
               mario_pos, frame_cnt, out_m, 16'(fcnt_m));
    end
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    frame_pulse("same_cycle_next");
  endtask

  task automatic test_wrap_stall();
    logic [31:0] d;
    d = $urandom();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    fcnt_m = 65535;
    wr(2'd3, 32'h0);
    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    out_m = sh_m; out_b = sh_b; out_i = sh_i; armed = 1'b0;
    fcnt_m = 0;
    vectors++;
    if (frame_cnt !== 16'h0000 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_cnt: got cnt=%h rdy=%b expected 0000 0", frame_cnt, wr_ready);
    end
    // Write presented during COMMIT, held until accepted
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = d;
    @(negedge clk);
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_ready: got wr_ready=%b expected 1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    sh_m = exp_pos(d);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    wr(2'd3, 32'h0);
    frame_pulse("stall_commit");
    vectors++;
    if (mario_pos !== exp_pos(d)) begin
      miscompares++;
      $display("FAIL stall_write: got m=%h expected %h", mario_pos, exp_pos(d));
    end
  endtask

  task automatic test_reset_mid_armed();
    wr(2'd0, $urandom());
    wr(2'd1, $urandom());
    wr(2'd3, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (mario_pos !== MarioRst || barril_pos !== BarrilRst || frame_cnt !== 16'h0000 ||
        wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: got m=%h b=%h cnt=%h rdy=%b expected init, 0000, 1",
               mario_pos, barril_pos, frame_cnt, wr_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    frame_pulse("after_reset");
    repeat (4) @(negedge clk);
    vectors++;
    if (mario_pos !== MarioRst || barril_pos !== BarrilRst || in1 !== 1'b0 ||
        frame_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_armed: got m=%h b=%h in1=%b cnt=%h expected init, cnt 0000",
               mario_pos, barril_pos, in1, frame_cnt);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_no_commit();
    test_commit();
    test_clamp();
    test_random();
    test_same_cycle();
    test_wrap_stall();
    test_reset_mid_armed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
